// File: rtl/memory_controller_pkg.sv
// Shared state encoding and widths for the memory_controller block.
package memory_controller_pkg;

    localparam int unsigned WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/memory_controller_if.sv
// CPU-side and memory-side signal bundle of memory_controller.
// The slave modport is the controller's view; master is the surrounding system.
interface memory_controller_if #(
    parameter int unsigned DATAWIDTH_BUS = 32
);

    logic                     CPU_REQ;
    logic                     CPU_WE;
    logic [DATAWIDTH_BUS-1:0] CPU_ADDR;
    logic [DATAWIDTH_BUS-1:0] CPU_WDATA;
    logic [DATAWIDTH_BUS-1:0] CPU_RDATA;
    logic                     CPU_DONE;
    logic                     CPU_BUSY;
    logic                     CPU_TIMEOUT;

    logic                     MEM_RD;
    logic                     MEM_WR;
    logic [DATAWIDTH_BUS-1:0] MEM_ADDR;
    logic [DATAWIDTH_BUS-1:0] MEM_WDATA;
    logic [DATAWIDTH_BUS-1:0] MEM_RDATA;
    logic                     MEM_ACK;

    modport slave (
        input  CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA, MEM_RDATA, MEM_ACK,
        output CPU_RDATA, CPU_DONE, CPU_BUSY, CPU_TIMEOUT,
        output MEM_RD, MEM_WR, MEM_ADDR, MEM_WDATA
    );

    modport master (
        output CPU_REQ, CPU_WE, CPU_ADDR, CPU_WDATA, MEM_RDATA, MEM_ACK,
        input  CPU_RDATA, CPU_DONE, CPU_BUSY, CPU_TIMEOUT,
        input  MEM_RD, MEM_WR, MEM_ADDR, MEM_WDATA
    );

endinterface

// File: rtl/memory_controller_wait_counter.sv
// Access-cycle counter; terminal_c flags the last permitted ACCESS cycle.
module memory_controller_wait_counter
    import memory_controller_pkg::*;
#(
    parameter int unsigned MEM_WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal_c
);

    logic [WAIT_CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WAIT_CNT_W'(1);
        end
    end

    assign terminal_c = (count == WAIT_CNT_W'(MEM_WAIT_CYCLES - 1));

endmodule

// File: rtl/memory_controller.sv
// Single-outstanding CPU-to-memory access controller with a bounded wait.
// Optional MEMORY_CONTROLLER_ALIGN_CHECK_EN rejects misaligned requests instead of aligning them.
module memory_controller
    import memory_controller_pkg::*;
#(
    parameter int unsigned DATAWIDTH_BUS   = 32,
    parameter int unsigned MEM_WAIT_CYCLES = 2
) (
    input  logic               MEMORY_CONTROLLER_CLOCK_50,
    input  logic               MEMORY_CONTROLLER_RESET_InHigh,
    memory_controller_if.slave bus
);

    logic clk;
    logic rst;

    assign clk = MEMORY_CONTROLLER_CLOCK_50;
    assign rst = MEMORY_CONTROLLER_RESET_InHigh;

    state_t state_q;
    state_t state_d;

    logic                     we_q;
    logic                     we_d;
    logic [DATAWIDTH_BUS-1:0] addr_q;
    logic [DATAWIDTH_BUS-1:0] wdata_q;
    logic [DATAWIDTH_BUS-1:0] rdata_q;
    logic [DATAWIDTH_BUS-1:0] addr_in;
    logic                     timeout_q;
    logic                     done_q;
    logic                     busy_q;
    logic                     rd_q;
    logic                     wr_q;

    logic accept;
    logic complete;
    logic skip;
    logic cnt_clear;
    logic cnt_enable;
    logic terminal_c;
    logic rd_d;
    logic wr_d;

`ifdef MEMORY_CONTROLLER_ALIGN_CHECK_EN
    // Misaligned requests bypass memory entirely and report as a timeout.
    assign addr_in = bus.CPU_ADDR;
    assign skip    = (bus.CPU_ADDR[1:0] != 2'b00);
`else
    // Word accesses only: the byte offset is dropped before reaching memory.
    assign addr_in = bus.CPU_ADDR & ~DATAWIDTH_BUS'(3);
    assign skip    = 1'b0;
`endif

    memory_controller_wait_counter #(
        .MEM_WAIT_CYCLES(MEM_WAIT_CYCLES)
    ) u_wait_counter (
        .clk       (clk),
        .rst       (rst),
        .clear     (cnt_clear),
        .enable    (cnt_enable),
        .terminal_c(terminal_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, handshake decisions and next-cycle strobe values.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        complete   = 1'b0;
        cnt_clear  = 1'b0;
        cnt_enable = 1'b0;
        we_d       = we_q;
        rd_d       = 1'b0;
        wr_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.CPU_REQ) begin
                    accept    = 1'b1;
                    cnt_clear = 1'b1;
                    we_d      = bus.CPU_WE;
                    state_d   = skip ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                cnt_enable = 1'b1;
                if (bus.MEM_ACK || terminal_c) begin
                    complete = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rd_d = (state_d == ACCESS) && !we_d;
        wr_d = (state_d == ACCESS) && we_d;
    end

    // Request latches, read capture and registered status/strobe outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
        end else begin
            we_q   <= we_d;
            done_q <= (state_d == DONE);
            busy_q <= (state_d != IDLE);
            rd_q   <= rd_d;
            wr_q   <= wr_d;

            if (accept) begin
                addr_q  <= addr_in;
                wdata_q <= bus.CPU_WDATA;
            end

            if (complete) begin
                timeout_q <= !bus.MEM_ACK;
                if (!we_q) begin
                    rdata_q <= bus.MEM_RDATA;
                end
            end else if (accept && skip) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign bus.CPU_RDATA   = rdata_q;
    assign bus.CPU_DONE    = done_q;
    assign bus.CPU_BUSY    = busy_q;
    assign bus.CPU_TIMEOUT = timeout_q;
    assign bus.MEM_RD      = rd_q;
    assign bus.MEM_WR      = wr_q;
    assign bus.MEM_ADDR    = addr_q;
    assign bus.MEM_WDATA   = wdata_q;

endmodule

// File: tb/tb_memory_controller.sv
// Scoreboard bench for memory_controller: transaction-level timing/data model,
// queue of expected accesses, and an independent per-cycle monitor.
module tb_memory_controller;

    localparam int unsigned DW       = 32;
    localparam int unsigned W        = 2;
    localparam int          N_HOLD   = 40;
    localparam int          N_RANDOM = 300;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    int n_vec = 0;
    int n_err = 0;

    bit mon_en    = 1'b0;
    bit salt_en   = 1'b0;
    bit hold_mode = 1'b0;
    int cur_d     = 99;
    int next_free = 0;
    int acc_idx   = 0;

    logic [DW-1:0] model_rdata = '0;

    typedef struct {
        int            n;
        int            k;
        bit            we;
        logic [DW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        bit            timeout;
    } txn_t;

    txn_t q[$];

    memory_controller_if #(.DATAWIDTH_BUS(DW)) bus ();

    memory_controller #(
        .DATAWIDTH_BUS  (DW),
        .MEM_WAIT_CYCLES(W)
    ) dut (
        .MEMORY_CONTROLLER_CLOCK_50    (clk),
        .MEMORY_CONTROLLER_RESET_InHigh(rst),
        .bus                           (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents; an optional per-cycle salt pins down the capture edge.
    function automatic logic [DW-1:0] rd_fn(input logic [DW-1:0] a);
        if (a == 32'h0000_0800) return 32'hC600_2001;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign bus.MEM_RDATA = rd_fn(bus.MEM_ADDR) ^ (salt_en ? DW'(cyc) : '0);

    function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endfunction

    // Memory responder: acknowledges in strobe cycle cur_d, random noise otherwise.
    always @(negedge clk) begin
        if (bus.MEM_RD || bus.MEM_WR) begin
            bus.MEM_ACK = (acc_idx == cur_d);
            acc_idx++;
        end else begin
            bus.MEM_ACK = 1'($urandom_range(0, 1));
            acc_idx = 0;
        end
    end

    // Monitor: compares every cycle against the front of the expected queue.
    always @(negedge clk) begin
        txn_t t;
        bit   eb;
        bit   erd;
        bit   ewr;
        bit   ed;
        if (mon_en) begin
            eb  = 1'b0;
            erd = 1'b0;
            ewr = 1'b0;
            ed  = 1'b0;
            if (q.size() > 0) begin
                t   = q[0];
                eb  = (cyc > t.n) && (cyc <= t.n + t.k + 1);
                erd = !t.we && (cyc > t.n) && (cyc <= t.n + t.k);
                ewr = t.we && (cyc > t.n) && (cyc <= t.n + t.k);
                ed  = (cyc == t.n + t.k + 1);
            end
            chk("busy",   DW'(bus.CPU_BUSY), DW'(eb));
            chk("mem_rd", DW'(bus.MEM_RD),   DW'(erd));
            chk("mem_wr", DW'(bus.MEM_WR),   DW'(ewr));
            chk("done",   DW'(bus.CPU_DONE), DW'(ed));
            if (ed) begin
                chk("rdata",     bus.CPU_RDATA,       t.rdata);
                chk("timeout",   DW'(bus.CPU_TIMEOUT), DW'(t.timeout));
                chk("mem_addr",  bus.MEM_ADDR,        t.addr);
                chk("mem_wdata", bus.MEM_WDATA,       t.wdata);
                void'(q.pop_front());
            end
        end
    end

    task automatic idle_cycle();
        if (cyc < next_free) begin
            bus.CPU_REQ = hold_mode ? 1'b1 : 1'($urandom_range(0, 1));
        end else begin
            bus.CPU_REQ = 1'b0;
        end
        bus.CPU_WE    = 1'($urandom_range(0, 1));
        bus.CPU_ADDR  = $urandom;
        bus.CPU_WDATA = $urandom;
        @(negedge clk);
    endtask

    // Issue one access at the first cycle the controller can take it.
    task automatic issue(input bit we, input logic [DW-1:0] addr, input logic [DW-1:0] wdata,
                         input int d, input int gap);
        txn_t          t;
        int            k;
        bit            to;
        bit            skip;
        logic [DW-1:0] ea;
        repeat (gap) idle_cycle();
        while (cyc < next_free) idle_cycle();

        skip = 1'b0;
        ea   = addr;
`ifdef MEMORY_CONTROLLER_ALIGN_CHECK_EN
        skip = (addr[1:0] != 2'b00);
`else
        ea[1:0] = 2'b00;
`endif
        if (skip) begin
            k  = 0;
            to = 1'b1;
        end else begin
            k  = (d < int'(W)) ? d + 1 : int'(W);
            to = (d >= int'(W));
            if (!we) model_rdata = rd_fn(ea) ^ (salt_en ? DW'(cyc + k) : '0);
        end

        t.n       = cyc;
        t.k       = k;
        t.we      = we;
        t.addr    = ea;
        t.wdata   = wdata;
        t.rdata   = model_rdata;
        t.timeout = to;
        q.push_back(t);
        cur_d     = d;
        next_free = cyc + k + 2;

        bus.CPU_REQ   = 1'b1;
        bus.CPU_WE    = we;
        bus.CPU_ADDR  = addr;
        bus.CPU_WDATA = wdata;
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rdata"},   bus.CPU_RDATA,         '0);
        chk({tag, "_done"},    DW'(bus.CPU_DONE),     '0);
        chk({tag, "_busy"},    DW'(bus.CPU_BUSY),     '0);
        chk({tag, "_timeout"}, DW'(bus.CPU_TIMEOUT),  '0);
        chk({tag, "_mem_rd"},  DW'(bus.MEM_RD),       '0);
        chk({tag, "_mem_wr"},  DW'(bus.MEM_WR),       '0);
        chk({tag, "_addr"},    bus.MEM_ADDR,          '0);
        chk({tag, "_wdata"},   bus.MEM_WDATA,         '0);
    endtask

    // Reset during the second ACCESS cycle of a stalled read.
    task automatic reset_abort();
        for (int i = 0; i < 50 && cyc < next_free; i++) begin
            bus.CPU_REQ = 1'b0;
            @(negedge clk);
        end
        mon_en        = 1'b0;
        cur_d         = 99;
        bus.CPU_REQ   = 1'b1;
        bus.CPU_WE    = 1'b0;
        bus.CPU_ADDR  = 32'h0000_0900;
        bus.CPU_WDATA = 32'hA5A5_A5A5;
        @(negedge clk);
        bus.CPU_REQ = 1'b0;
        chk("abort_rd_cycle0", DW'(bus.MEM_RD), DW'(1));
        @(negedge clk);
        chk("abort_rd_cycle1", DW'(bus.MEM_RD), DW'(1));
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("abort");
        rst = 1'b0;
        @(negedge clk);
        chk("abort_no_done", DW'(bus.CPU_DONE), '0);
        chk("abort_idle",    DW'(bus.CPU_BUSY), '0);
        model_rdata = '0;
        next_free   = cyc;
        mon_en      = 1'b1;
    endtask

    initial begin
        bus.CPU_REQ   = 1'b0;
        bus.CPU_WE    = 1'b0;
        bus.CPU_ADDR  = '0;
        bus.CPU_WDATA = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        next_free = cyc;
        mon_en    = 1'b1;

        issue(1'b0, 32'h0000_0800, 32'h0000_0000, 99, 0);
        issue(1'b1, 32'h0000_0804, 32'h1234_5678, 0, 1);
        issue(1'b0, 32'h0000_0802, 32'hDEAD_BEEF, 0, 0);
        issue(1'b0, 32'h0000_0800, 32'h0000_0000, int'(W) - 1, 2);
        issue(1'b1, 32'h0000_0FFC, 32'hFFFF_FFFF, 99, 0);

        reset_abort();

        salt_en   = 1'b1;
        hold_mode = 1'b1;
        repeat (N_HOLD) begin
            issue(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(0, W + 1), 0);
        end
        hold_mode = 1'b0;
        repeat (N_RANDOM) begin
            issue(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(0, W + 1),
                  $urandom_range(0, 3));
        end

        bus.CPU_REQ = 1'b0;
        for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
        chk("drain", DW'(q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
